serial_magnitude_comparator: RTL and testbench
==============================================

Name: serial_magnitude_comparator

Overview:
Parametrised, multi-cycle magnitude comparator that supersedes the fixed 8-bit combinational comparator and the two's-complement comparator. It accepts two WIDTH-bit operands over a valid/ready handshake and scans them MSB-first, DIGIT bits per cycle. It supports unsigned or two's-complement mode per transaction and optional early exit on the first differing digit. It returns registered eq/lt/gt flags over an output valid/ready handshake.

Parameters:
WIDTH, 8, operand width in bits (>= 2)
DIGIT, 1, bits compared per RUN cycle; WIDTH % DIGIT must equal 0, otherwise elaboration fails via $error
EARLY_EXIT, 1, 1 = finish on first differing digit; 0 = always run STEPS cycles (constant time)
(derived) STEPS = WIDTH/DIGIT; counter width = $clog2(STEPS)+1

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands/mode valid
in_ready  output  1  block can accept (IDLE and not rst)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned
out_valid  output  1  result valid, held until accepted
out_ready  input  1  consumer accepts result
eq  output  1  A == B
lt  output  1  A < B
gt  output  1  A > B
steps_used  output  $clog2(STEPS)+1  RUN cycles consumed by this result

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; out_valid, eq, lt, gt, steps_used=0; shift registers cleared. in_ready=0 while rst is high. rst mid-RUN or mid-DONE aborts the operation, and no result is produced.
- in_ready = (state==IDLE) && !rst. It is combinational from state only, with no dependence on in_valid.
- IDLE: on in_valid && in_ready, capture a and b into shift regs; if signed_mode, invert bit WIDTH-1 of both (maps two's complement to offset-binary). Clear the counter, then go to RUN.
- RUN, each cycle: compare the top DIGIT bits of both shift regs as unsigned.
  - Digits differ and no decision latched yet: latch lt/gt.
  - EARLY_EXIT=1: go to DONE at this edge.
  - EARLY_EXIT=0: record the decision, keep shifting, and ignore later digits.
  - Counter increments every RUN cycle. When the counter reaches STEPS-1 (last digit), go to DONE; eq=1 only if no difference was ever seen.
  - Exactly one of eq/lt/gt is 1 when out_valid=1.
- Latency: k = RUN cycles = index of the first differing digit (1-based) if EARLY_EXIT=1, else STEPS. Equal operands give k=STEPS. out_valid rises k edges after the accepting edge. steps_used=k.
- DONE: out_valid=1; eq/lt/gt/steps_used stable. in_valid is ignored (in_ready=0). On out_ready=1, go to IDLE next edge, clear out_valid and flags. in_ready returns 1 in that same cycle. No overlap between result presentation and new acceptance.
- Operands a/b/signed_mode are sampled only at the accepting edge; later changes have no effect.
- Min transaction period: 1 (accept) + k + 1 (DONE with out_ready=1) cycles.

Decomposition:
- Package cmp_pkg: state enum (IDLE, RUN, DONE); packed struct cmp_result_t {eq, lt, gt}; localparam helper function for counter width.
- One sub-module, digit_compare: combinational, parameter DIGIT, inputs x,y [DIGIT-1:0], outputs d_eq, d_lt. It is instantiated once in the RUN datapath.

Test Plan:
1. WIDTH=8, DIGIT=1, EARLY_EXIT=1: a=0x80, b=0x00, signed_mode=0 -> gt=1, steps_used=1. Same operands with signed_mode=1 -> lt=1 (-128 < 0), steps_used=1.
2. a=b=0x5A, unsigned -> eq=1, out_valid 8 edges after accept, steps_used=8. Repeat all 20 pairs of the legacy 8-bit bit-toggle sequence and check against a golden model in both modes.
3. a=0x40, b=0x00: EARLY_EXIT=1 -> gt, steps_used=2; EARLY_EXIT=0 -> gt, steps_used=8 (constant time).
4. WIDTH=16, DIGIT=4: a=0x1234, b=0x1235 unsigned -> lt, steps_used=4. a=0xFFFF, b=0x0001 signed -> lt (-1 < 1), steps_used=1.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid; pulse in_valid with new operands -> out_valid and flags stable, in_ready=0, new operands never captured. out_ready=1 -> out_valid=0 next edge, in_ready=1.
6. Assert rst for 1 cycle during RUN (after 3 digits) -> next cycle out_valid=0, eq/lt/gt=0, in_ready=1. A subsequent a=0x01, b=0x02 transaction -> lt, steps_used=8.

Source files
------------

// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM states, result flags
// and the helper that sizes the step counter.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_result_t;

  // Wide enough to hold STEPS itself, not just STEPS-1.
  function automatic int cnt_width(input int width, input int digit);
    return $clog2(width / digit) + 1;
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Operand and result handshake bundle between a producer/consumer (master)
// and the comparator (slave).
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             lt;
  logic             gt;
  logic [CNT_W-1:0] steps_used;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, eq, lt, gt, steps_used
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, eq, lt, gt, steps_used
  );
endinterface

// File: rtl/serial_magnitude_comparator_digit_compare.sv
// Unsigned comparison of one DIGIT-wide slice of each operand.
module digit_compare #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             d_eq,
  output logic             d_lt
);
  assign d_eq = (x == y);
  assign d_lt = (x < y);
endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, with
// optional two's-complement mode and early exit on the first differing digit.
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 1,
  parameter int EARLY_EXIT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_magnitude_comparator_if.slave  bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(WIDTH, DIGIT);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_magnitude_comparator: WIDTH must be a multiple of DIGIT");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("serial_magnitude_comparator: WIDTH must be at least 2");
  end

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_steps;
  logic             r_decided;
  logic             r_dec_lt;
  logic             r_out_valid;
  cmp_result_t      r_result;
  cmp_result_t      w_final;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_d_eq;
  logic             w_d_lt;
  logic             w_first_diff;
  logic             w_last;
  logic [WIDTH-1:0] w_flip;

  assign w_in_ready   = (r_state == IDLE) && !rst;
  assign w_accept     = bus.in_valid && w_in_ready;
  // Flipping the sign bit maps two's complement onto offset binary, so the
  // unsigned digit scan orders signed operands correctly.
  assign w_flip       = {bus.signed_mode, {(WIDTH-1){1'b0}}};
  assign w_first_diff = !w_d_eq && !r_decided;
  assign w_last       = (r_cnt == CNT_W'(STEPS - 1));

  digit_compare #(.DIGIT(DIGIT)) u_digit (
    .x    (r_sa[WIDTH-1 -: DIGIT]),
    .y    (r_sb[WIDTH-1 -: DIGIT]),
    .d_eq (w_d_eq),
    .d_lt (w_d_lt)
  );

  // NOTE: every signal written in always_comb gets a default first; a path
  // that skips an assignment would infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = RUN;
      RUN:  if (((EARLY_EXIT != 0) && w_first_diff) || w_last) w_next = DONE;
      DONE: if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_final = '0;
    if (r_decided) begin
      w_final.lt = r_dec_lt;
      w_final.gt = !r_dec_lt;
    end else if (!w_d_eq) begin
      w_final.lt = w_d_lt;
      w_final.gt = !w_d_lt;
    end else begin
      w_final.eq = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa        <= '0;
      r_sb        <= '0;
      r_cnt       <= '0;
      r_steps     <= '0;
      r_decided   <= 1'b0;
      r_dec_lt    <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sa      <= bus.a ^ w_flip;
            r_sb      <= bus.b ^ w_flip;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_dec_lt  <= 1'b0;
          end
        end
        RUN: begin
          r_sa  <= r_sa << DIGIT;
          r_sb  <= r_sb << DIGIT;
          r_cnt <= r_cnt + 1'b1;
          if (w_first_diff) begin
            r_decided <= 1'b1;
            r_dec_lt  <= w_d_lt;
          end
          if (w_next == DONE) begin
            r_result    <= w_final;
            r_steps     <= r_cnt + 1'b1;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_steps     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.eq         = r_result.eq;
  assign bus.lt         = r_result.lt;
  assign bus.gt         = r_result.gt;
  assign bus.steps_used = r_steps;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for three comparator configurations: 8b/1-bit early exit, 8b/1-bit
// constant time, and 16b/4-bit early exit, checked against an integer model.
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid_d  [3];
  logic [15:0] a_d         [3];
  logic [15:0] b_d         [3];
  logic        sm_d        [3];
  logic        out_ready_d [3];
  logic        ov [3];
  logic        ir [3];
  logic        eqo[3];
  logic        lto[3];
  logic        gto[3];
  logic [3:0]  su [3];

  int tests_run = 0;
  int tests_failed = 0;

  serial_magnitude_comparator_if #(.WIDTH(8),  .CNT_W(4)) if0 ();
  serial_magnitude_comparator_if #(.WIDTH(8),  .CNT_W(4)) if1 ();
  serial_magnitude_comparator_if #(.WIDTH(16), .CNT_W(3)) if2 ();

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.in_valid = in_valid_d[0];  assign if0.a = a_d[0][7:0];  assign if0.b = b_d[0][7:0];
  assign if0.signed_mode = sm_d[0];     assign if0.out_ready = out_ready_d[0];
  assign if1.in_valid = in_valid_d[1];  assign if1.a = a_d[1][7:0];  assign if1.b = b_d[1][7:0];
  assign if1.signed_mode = sm_d[1];     assign if1.out_ready = out_ready_d[1];
  assign if2.in_valid = in_valid_d[2];  assign if2.a = a_d[2];       assign if2.b = b_d[2];
  assign if2.signed_mode = sm_d[2];     assign if2.out_ready = out_ready_d[2];

  assign ov[0] = if0.out_valid; assign ir[0] = if0.in_ready; assign su[0] = if0.steps_used;
  assign eqo[0] = if0.eq; assign lto[0] = if0.lt; assign gto[0] = if0.gt;
  assign ov[1] = if1.out_valid; assign ir[1] = if1.in_ready; assign su[1] = if1.steps_used;
  assign eqo[1] = if1.eq; assign lto[1] = if1.lt; assign gto[1] = if1.gt;
  assign ov[2] = if2.out_valid; assign ir[2] = if2.in_ready; assign su[2] = {1'b0, if2.steps_used};
  assign eqo[2] = if2.eq; assign lto[2] = if2.lt; assign gto[2] = if2.gt;

  function automatic int cfg_w(input int sel);
    return (sel == 2) ? 16 : 8;
  endfunction
  function automatic int cfg_d(input int sel);
    return (sel == 2) ? 4 : 1;
  endfunction
  function automatic bit cfg_ee(input int sel);
    return sel != 1;
  endfunction

  // Reference: compare operands as integers; latency is the 1-based index of
  // the first differing digit (early exit) or the full digit count.
  task automatic model(input int sel, input logic [15:0] av, input logic [15:0] bv,
                       input logic smv, output logic e, output logic l, output logic g,
                       output int k);
    int w, d, steps, ua, ub, ia, ib;
    w = cfg_w(sel);
    d = cfg_d(sel);
    steps = w / d;
    ua = int'(av) & ((1 << w) - 1);
    ub = int'(bv) & ((1 << w) - 1);
    ia = ua;
    ib = ub;
    if (smv && ua >= (1 << (w - 1))) ia = ua - (1 << w);
    if (smv && ub >= (1 << (w - 1))) ib = ub - (1 << w);
    e = (ia == ib);
    l = (ia < ib);
    g = (ia > ib);
    k = steps;
    if (cfg_ee(sel)) begin
      for (int i = 0; i < steps; i++) begin
        if (((ua >> (w - (i + 1) * d)) & ((1 << d) - 1)) !=
            ((ub >> (w - (i + 1) * d)) & ((1 << d) - 1))) begin
          k = i + 1;
          break;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int sel, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask

  task automatic do_txn(input int sel, input logic [15:0] av, input logic [15:0] bv, input logic smv);
    logic e, l, g;
    int k, n;
    model(sel, av, bv, smv, e, l, g, k);
    @(negedge clk);
    in_valid_d[sel] = 1'b1;
    a_d[sel] = av;
    b_d[sel] = bv;
    sm_d[sel] = smv;
    chk("in_ready_idle", sel, 32'(ir[sel]), 32'd1);
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the result must not depend on them.
    in_valid_d[sel] = 1'b0;
    a_d[sel] = 16'($urandom);
    b_d[sel] = 16'($urandom);
    sm_d[sel] = 1'($urandom);
    n = 0;
    while (!ov[sel] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", sel, 32'(n), 32'(k));
    chk("eq", sel, 32'(eqo[sel]), 32'(e));
    chk("lt", sel, 32'(lto[sel]), 32'(l));
    chk("gt", sel, 32'(gto[sel]), 32'(g));
    chk("steps_used", sel, 32'(su[sel]), 32'(k));
    out_ready_d[sel] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_d[sel] = 1'b0;
    chk("out_valid_cleared", sel, 32'(ov[sel]), 32'd0);
    chk("in_ready_return", sel, 32'(ir[sel]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ta, tb;
    logic e, l, g;
    int k, n;
    for (int s = 0; s < 3; s++) begin
      in_valid_d[s] = 1'b0; a_d[s] = '0; b_d[s] = '0; sm_d[s] = 1'b0; out_ready_d[s] = 1'b0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) chk("in_ready_in_reset", s, 32'(ir[s]), 32'd0);
    rst = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("reset_in_ready", s, 32'(ir[s]), 32'd1);
      chk("reset_out_valid", s, 32'(ov[s]), 32'd0);
      chk("reset_flags", s, 32'({eqo[s], lto[s], gto[s]}), 32'd0);
      chk("reset_steps", s, 32'(su[s]), 32'd0);
    end

    // Directed cases
    do_txn(0, 16'h0080, 16'h0000, 1'b0);
    do_txn(0, 16'h0080, 16'h0000, 1'b1);
    do_txn(0, 16'h005A, 16'h005A, 1'b0);
    do_txn(0, 16'h0040, 16'h0000, 1'b0);
    do_txn(1, 16'h0040, 16'h0000, 1'b0);
    do_txn(2, 16'h1234, 16'h1235, 1'b0);
    do_txn(2, 16'hFFFF, 16'h0001, 1'b1);

    // Bit-toggle sequence, both modes
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 20; i++) begin
        if (i < 8)       begin ta = 16'(1 << i);           tb = 16'h0000; end
        else if (i < 16) begin ta = 16'(8'hFF ^ (1 << (i - 8))); tb = 16'h00FF; end
        else if (i == 16) begin ta = 16'h00AA; tb = 16'h0055; end
        else if (i == 17) begin ta = 16'h0055; tb = 16'h00AA; end
        else if (i == 18) begin ta = 16'h007F; tb = 16'h0080; end
        else              begin ta = 16'h0000; tb = 16'h00FF; end
        do_txn(0, ta, tb, 1'(m));
      end
    end

    // Randomized on every configuration
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 25; i++) begin
        ta = 16'($urandom);
        tb = (i % 5 == 0) ? ta : 16'($urandom);
        if (i % 4 == 1) tb = ta ^ 16'(1 << $urandom_range(0, 15));
        do_txn(s, ta, tb, 1'($urandom));
      end
    end

    // Backpressure: result held, new operands ignored while DONE
    model(0, 16'h0003, 16'h0009, 1'b0, e, l, g, k);
    @(negedge clk);
    in_valid_d[0] = 1'b1; a_d[0] = 16'h0003; b_d[0] = 16'h0009; sm_d[0] = 1'b0;
    @(posedge clk);
    #1;
    in_valid_d[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_latency", 0, 32'(n), 32'(k));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid_d[0] = (c == 2); a_d[0] = 16'h00F0; b_d[0] = 16'h0001;
      chk("bp_in_ready", 0, 32'(ir[0]), 32'd0);
      @(posedge clk);
      #1;
      chk("bp_out_valid", 0, 32'(ov[0]), 32'd1);
      chk("bp_flags", 0, 32'({eqo[0], lto[0], gto[0]}), 32'({e, l, g}));
      chk("bp_steps", 0, 32'(su[0]), 32'(k));
    end
    in_valid_d[0] = 1'b0;
    out_ready_d[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_d[0] = 1'b0;
    chk("bp_release_valid", 0, 32'(ov[0]), 32'd0);
    chk("bp_release_ready", 0, 32'(ir[0]), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_no_capture", 0, 32'(ir[0]), 32'd1);

    // Reset during RUN after three digits
    @(negedge clk);
    in_valid_d[1] = 1'b1; a_d[1] = 16'h0000; b_d[1] = 16'h0000; sm_d[1] = 1'b0;
    @(posedge clk);
    #1;
    in_valid_d[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 1, 32'(ov[1]), 32'd0);
    chk("rst_flags", 1, 32'({eqo[1], lto[1], gto[1]}), 32'd0);
    chk("rst_in_ready_high", 1, 32'(ir[1]), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 1, 32'(ir[1]), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_result", 1, 32'(ov[1]), 32'd0);
    do_txn(1, 16'h0001, 16'h0002, 1'b0);
    do_txn(0, 16'h0001, 16'h0002, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
